pool_ctrl: RTL

POOL_CTRL -- requirements
Module: pool_ctrl

---
 rtl/pool_pkg.sv | 41 ++++
 rtl/pool_max_reduce.sv | 33 +++
 rtl/pool_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling controller: word width, layer codes,
// per-layer output geometry and pooling window size.
package pool_pkg;

   localparam int DATSIZE = 22;

   localparam logic [3:0] CODE_POOL1 = 4'b0011;
   localparam logic [3:0] CODE_POOL2 = 4'b0101;
   localparam logic [3:0] CODE_POOL3 = 4'b0111;

   // Number of buffer reads per output (each read returns a horizontal pair).
   localparam int RD_2X2 = 2;
   localparam int RD_4X4 = 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef struct packed {
      logic       valid;
      logic       win4;
      logic [5:0] c_last;
      logic [3:0] y_last;
      logic [3:0] x_last;
   } layer_cfg_t;

   function automatic layer_cfg_t layer_cfg(input logic [3:0] code);
      layer_cfg_t cfg;
      cfg = '0;
      case (code)
         CODE_POOL1: cfg = '{valid: 1'b1, win4: 1'b0, c_last: 6'd15, y_last: 4'd15, x_last: 4'd15};
         CODE_POOL2: cfg = '{valid: 1'b1, win4: 1'b0, c_last: 6'd31, y_last: 4'd7,  x_last: 4'd7};
         CODE_POOL3: cfg = '{valid: 1'b1, win4: 1'b1, c_last: 6'd63, y_last: 4'd1,  x_last: 4'd1};
         default:    cfg = '0;
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/pool_max_reduce.sv
// Signed 3-input max of the running register and both halves of a returned
// word pair; load ignores the register so the first return of an output seeds it.
module pool_max_reduce
   import pool_pkg::*;
#(
   parameter int W = 22
) (
   input  logic [W-1:0] cur,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   input  logic         load,
   output logic [W-1:0] result
);

   logic signed [W-1:0] cur_s;
   logic signed [W-1:0] lo_s;
   logic signed [W-1:0] hi_s;
   logic signed [W-1:0] pair_max;

   assign cur_s = cur;
   assign lo_s  = lo;
   assign hi_s  = hi;

   // Pure comparisons, so the most negative value needs no special handling.
   always_comb begin
      pair_max = (lo_s > hi_s) ? lo_s : hi_s;
      result   = pair_max;
      if (!load && (cur_s > pair_max)) begin
         result = cur_s;
      end
   end

endmodule

// File: rtl/pool_ctrl.sv
// Max-pooling pass controller: reads window pairs from the pool buffer, reduces
// them and writes one result per output. Optional macro POOL_RELU_EN clamps results at 0.
module pool_ctrl #(
   parameter int DATSIZE = pool_pkg::DATSIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             state,
   output logic                   busy,
   output logic                   done,
   output logic                   pb_read_en,
   output logic [3:0]             pb_read_y,
   output logic [3:0]             pb_read_x,
   output logic [5:0]             pb_read_c,
   output logic                   pb_read_updown,
   input  logic [2*DATSIZE-1:0]   pb_read_data,
   output logic                   cb_write_en,
   output logic [4:0]             cb_write_y,
   output logic [4:0]             cb_write_x,
   output logic [5:0]             cb_write_c,
   output logic [DATSIZE-1:0]     cb_write_data,
   output logic [2:0]             dbg_state
);
   import pool_pkg::*;

   logic [2:0]         st_q, st_d;
   layer_cfg_t         start_cfg;
   logic               win4_q;
   logic [5:0]         c_last_q;
   logic [3:0]         y_last_q, x_last_q;
   logic [5:0]         oc_q;
   logic [3:0]         oy_q, ox_q;
   logic [2:0]         k_q;
   logic [DATSIZE-1:0] max_q, max_d, wr_val;
   logic               rd_vld_q, rd_first_q;
   logic               rd_en, wr_en, k_last, last_out;

   assign start_cfg = layer_cfg(state);
   assign rd_en     = (st_q == ST_READ);
   assign wr_en     = (st_q == ST_WRITE);
   assign k_last    = win4_q ? (k_q == 3'(RD_4X4 - 1)) : (k_q == 3'(RD_2X2 - 1));
   assign last_out  = (oc_q == c_last_q) && (oy_q == y_last_q) && (ox_q == x_last_q);

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE:  if (start) st_d = start_cfg.valid ? ST_READ : ST_DONE;
         ST_READ:  if (k_last) st_d = ST_WAIT;
         ST_WAIT:  st_d = ST_WRITE;
         ST_WRITE: st_d = last_out ? ST_DONE : ST_READ;
         ST_DONE:  st_d = ST_IDLE;
         default:  st_d = ST_IDLE;
      endcase
   end

   // Read handshake: no backpressure; every cycle with pb_read_en high gets its
   // pair on pb_read_data exactly one cycle later, tracked by rd_vld_q/rd_first_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= ST_IDLE;
         win4_q     <= 1'b0;
         c_last_q   <= '0;
         y_last_q   <= '0;
         x_last_q   <= '0;
         oc_q       <= '0;
         oy_q       <= '0;
         ox_q       <= '0;
         k_q        <= '0;
         max_q      <= '0;
         rd_vld_q   <= 1'b0;
         rd_first_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         rd_vld_q   <= rd_en;
         rd_first_q <= rd_en && (k_q == 3'd0);
         if (rd_vld_q) begin
            max_q <= max_d;
         end
         case (st_q)
            ST_IDLE: begin
               if (start) begin
                  win4_q   <= start_cfg.win4;
                  c_last_q <= start_cfg.c_last;
                  y_last_q <= start_cfg.y_last;
                  x_last_q <= start_cfg.x_last;
                  oc_q     <= '0;
                  oy_q     <= '0;
                  ox_q     <= '0;
                  k_q      <= '0;
               end
            end
            ST_READ: k_q <= k_last ? 3'd0 : k_q + 3'd1;
            ST_WRITE: begin
               if (last_out) begin
                  oc_q <= '0;
                  oy_q <= '0;
                  ox_q <= '0;
               end else if (ox_q != x_last_q) begin
                  ox_q <= ox_q + 4'd1;
               end else begin
                  ox_q <= '0;
                  if (oy_q != y_last_q) begin
                     oy_q <= oy_q + 4'd1;
                  end else begin
                     oy_q <= '0;
                     oc_q <= oc_q + 6'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   pool_max_reduce #(.W(DATSIZE)) u_reduce (
      .cur    (max_q),
      .lo     (pb_read_data[DATSIZE-1:0]),
      .hi     (pb_read_data[2*DATSIZE-1:DATSIZE]),
      .load   (rd_first_q),
      .result (max_d)
   );

`ifdef POOL_RELU_EN
   assign wr_val = max_q[DATSIZE-1] ? '0 : max_q;
`else
   assign wr_val = max_q;
`endif

   // Address outputs are forced to 0 whenever their enable is low.
   always_comb begin
      pb_read_y      = '0;
      pb_read_x      = '0;
      pb_read_c      = '0;
      pb_read_updown = 1'b0;
      if (rd_en) begin
         pb_read_c = oc_q;
         if (win4_q) begin
            pb_read_y      = {oy_q[2:0], k_q[2]};
            pb_read_x      = {ox_q[2:0], k_q[0]};
            pb_read_updown = k_q[1];
         end else begin
            pb_read_y      = oy_q;
            pb_read_x      = ox_q;
            pb_read_updown = k_q[0];
         end
      end
   end

   assign pb_read_en    = rd_en;
   assign cb_write_en   = wr_en;
   assign cb_write_y    = wr_en ? {1'b0, oy_q} : 5'd0;
   assign cb_write_x    = wr_en ? {1'b0, ox_q} : 5'd0;
   assign cb_write_c    = wr_en ? oc_q : 6'd0;
   assign cb_write_data = wr_en ? wr_val : '0;
   assign busy          = (st_q == ST_READ) || (st_q == ST_WAIT) || (st_q == ST_WRITE);
   assign done          = (st_q == ST_DONE);
   assign dbg_state     = st_q;

endmodule
